mix_round_engine: RTL and testbench
===================================

Name: mix_round_engine

Overview:
- Parametrised, handshaked successor to the fixed 8-lane in-place mixing datapath used in the simulator benchmark suite.
- Accepts a seed vector of LANES words, applies a runtime-selected number of mixing rounds (one round per clock), then presents the digest on an output handshake.
- Serves as a synthesizable, sequential stress block for simulator benchmarking: it has deep blocking-assignment chains, multiply/shift/xor arithmetic, and an FSM.

Parameters:
- LANES, 8, number of state words; must be ≥2.
- WIDTH, 32, bits per word; all arithmetic is modulo 2^WIDTH.
- SHL, 16, left-shift amount in the xor step; must be < WIDTH.
- RW, 8, width of the round-count config.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  seed valid.
- in_ready  out  1  engine can accept a seed.
- in_data  in  LANES*WIDTH  seed; lane i is in bits [i*WIDTH +: WIDTH].
- rounds_cfg  in  RW  number of rounds; sampled only on acceptance.
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts the digest.
- out_data  out  LANES*WIDTH  digest; same lane packing as in_data.
- busy  out  1  high in RUN.
- round_cnt  out  RW  index of the next round to apply.

Behaviour:
- Reset (async assert) clears everything:
  - state=IDLE, all lanes=0, round_cnt=0, rounds_reg=0.
  - out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-RUN or mid-DONE discards all work immediately.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - Acceptance = in_valid && in_ready at a rising edge.
  - On acceptance: lanes<=in_data, rounds_reg<=rounds_cfg, round_cnt<=0.
  - Next state is RUN if rounds_cfg≠0, else DONE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge applies round r=round_cnt to the lanes and increments round_cnt.
  - When r==rounds_reg-1, go to DONE on that same edge.
- DONE:
  - out_valid=1, out_data=lanes; both are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid<=0.
  - A new seed is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency: out_valid rises exactly R edges after the acceptance edge, with R=rounds_cfg. R=0 gives out_valid on the next cycle with out_data=in_data.
- Round function, r = current round index zero-extended to WIDTH. Steps run sequentially. Within a step, lanes update in ascending i, and later lanes see already-updated earlier lanes (blocking semantics).
  - A: o[i] = o[i] + i.
  - B: o[i] = o[i] + o[(i+LANES-1)%LANES]. o[0] uses o[LANES-1] after step A.
  - C: o[i] = o[i] ^ (o[(i+3)%LANES] << SHL), truncated to WIDTH.
  - D: o[i] = o[i]*(2i+3) + r, truncated.
- The whole round is combinational from registered lanes, and the result is registered once per edge.
- in_data and rounds_cfg changes outside acceptance have no effect.

Optional Feature:
- Macro: MIX_ROUND_ENGINE_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in RUN: go to IDLE, round_cnt<=0, no out_valid pulse; lanes keep their partial value, which is not observable.
  - abort in IDLE or DONE is ignored; a DONE digest must still be drained.
- Undefined: no abort port; a RUN always completes.

Test Plan:
- LANES=2, WIDTH=8, SHL=4; in_data=16'h0100 (o0=0, o1=1), rounds_cfg=1 → one edge after acceptance, out_valid=1 and out_data=16'hB4C6.
- Defaults; rounds_cfg=0 with an arbitrary seed → out_valid the cycle after acceptance, out_data=seed, busy never high.
- Defaults; rounds_cfg=5, out_ready=0 for 10 cycles after out_valid → out_data stable and in_ready=0 throughout; out_ready=1 → out_valid drops next cycle, in_ready=1.
- Defaults; rounds_cfg=200, assert rst asynchronously at round_cnt=50 → outputs zero immediately (no clock edge needed), state IDLE; the next seed runs normally with matching model results.
- Back-to-back: two seeds with rounds_cfg=3 and 7, out_ready tied 1 → digests match the reference model; second acceptance occurs ≥1 cycle after the first out handshake.
- ABORT_EN defined; rounds_cfg=10, abort at round_cnt=4 → IDLE, no out_valid; with abort while in DONE → digest is still presented.

Source files
------------

// File: rtl/mix_round_engine.sv
// Handshaked multi-round lane mixer: seed in, rounds_cfg rounds (one per clock), digest held until out_ready.
// Optional RUN abort via `MIX_ROUND_ENGINE_ABORT_EN; default build has no abort port.
module mix_round_engine #(
    parameter int LANES = 8,
    parameter int WIDTH = 32,
    parameter int SHL   = 16,
    parameter int RW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MIX_ROUND_ENGINE_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [RW-1:0]          rounds_cfg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy,
    output logic [RW-1:0]          round_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] lanes [LANES];
    logic [WIDTH-1:0] mixed [LANES];
    logic [RW-1:0]    rounds_reg;
    logic             last_round;
    logic             abort_run;

`ifdef MIX_ROUND_ENGINE_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    // One full round; each step walks lanes in order so later lanes see updated earlier ones.
    always_comb begin
        for (int i = 0; i < LANES; i++) mixed[i] = lanes[i];
        for (int i = 0; i < LANES; i++) mixed[i] = mixed[i] + WIDTH'(i);
        for (int i = 0; i < LANES; i++) mixed[i] = mixed[i] + mixed[(i + LANES - 1) % LANES];
        for (int i = 0; i < LANES; i++) mixed[i] = mixed[i] ^ (mixed[(i + 3) % LANES] << SHL);
        for (int i = 0; i < LANES; i++)
            mixed[i] = WIDTH'(mixed[i] * WIDTH'(2 * i + 3)) + WIDTH'(round_cnt);
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = (state == S_IDLE);
        busy       = (state == S_RUN);
        out_valid  = (state == S_DONE);
        last_round = (round_cnt == rounds_reg - RW'(1));
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = (rounds_cfg != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (abort_run)       state_nxt = S_IDLE;
                else if (last_round) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) out_data[i*WIDTH +: WIDTH] = lanes[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            round_cnt  <= '0;
            rounds_reg <= '0;
            for (int i = 0; i < LANES; i++) lanes[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) lanes[i] <= in_data[i*WIDTH +: WIDTH];
                        rounds_reg <= rounds_cfg;
                        round_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    // Aborted lanes keep their partial value; it is never presented.
                    if (abort_run) begin
                        round_cnt <= '0;
                    end else begin
                        for (int i = 0; i < LANES; i++) lanes[i] <= mixed[i];
                        round_cnt <= round_cnt + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_round_engine.sv
// Randomized self-checking bench for mix_round_engine against a behavioural digest model.
module tb_mix_round_engine;
    localparam int L   = 8;
    localparam int W   = 32;
    localparam int RWD = 8;
    localparam int DW  = L * W;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [RWD-1:0] rounds_cfg;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic [RWD-1:0] round_cnt;

    logic           s_in_valid;
    logic           s_in_ready;
    logic [15:0]    s_in_data;
    logic [7:0]     s_rounds;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [15:0]    s_out_data;
    logic           s_busy;
    logic [7:0]     s_round_cnt;
`ifdef MIX_ROUND_ENGINE_ABORT_EN
    logic           abort;
    logic           s_abort;
`endif

    int checks   = 0;
    int failures = 0;

    mix_round_engine #(.LANES(L), .WIDTH(W), .SHL(16), .RW(RWD)) u_dut (
        .clk(clk), .rst(rst),
`ifdef MIX_ROUND_ENGINE_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rounds_cfg(rounds_cfg),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_cnt(round_cnt)
    );

    mix_round_engine #(.LANES(2), .WIDTH(8), .SHL(4), .RW(8)) u_small (
        .clk(clk), .rst(rst),
`ifdef MIX_ROUND_ENGINE_ABORT_EN
        .abort(s_abort),
`endif
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .rounds_cfg(s_rounds),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .busy(s_busy), .round_cnt(s_round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] seed, input int rounds);
        logic [W-1:0] o [L];
        logic [DW-1:0] res;
        for (int i = 0; i < L; i++) o[i] = seed[i*W +: W];
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < L; i++) o[i] = o[i] + W'(i);
            for (int i = 0; i < L; i++) o[i] = o[i] + o[(i + L - 1) % L];
            for (int i = 0; i < L; i++) o[i] = o[i] ^ (o[(i + 3) % L] << 16);
            for (int i = 0; i < L; i++) o[i] = W'(o[i] * W'(2 * i + 3)) + W'(r);
        end
        res = '0;
        for (int i = 0; i < L; i++) res[i*W +: W] = o[i];
        return res;
    endfunction

    function automatic logic [DW-1:0] rand_seed();
        logic [DW-1:0] s;
        for (int i = 0; i < L; i++) s[i*W +: W] = $urandom;
        return s;
    endfunction

    task automatic accept(input logic [DW-1:0] seed, input logic [RWD-1:0] rc);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("accept_ready", in_ready, 1);
        in_data    = seed;
        rounds_cfg = rc;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = rand_seed();
        rounds_cfg = RWD'($urandom);
    endtask

    task automatic wait_done(input int r, input logic [DW-1:0] exp, input string tag);
        int lat = 0;
        while (!out_valid && lat < 300) begin
            check_val("busy_run", busy, 1);
            check_val("round_cnt", round_cnt, lat);
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, r);
        check_val("busy_done", busy, 0);
        check_val({tag, "_digest"}, out_data, exp);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("drain_valid", out_valid, 0);
        check_val("drain_ready", in_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] seed, seed_b, exp_a, exp_b, cap, held;
        int rc, stall, n, cyc, sent, got, acc2, oh1;
        logic acc, oh;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; rounds_cfg = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_rounds = '0; s_out_ready = 1'b0;
`ifdef MIX_ROUND_ENGINE_ABORT_EN
        abort = 1'b0; s_abort = 1'b0;
`endif
        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_round_cnt", round_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-lane hand-computed vector
        s_in_data = 16'h0100; s_rounds = 8'd1; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check_val("small_busy", s_busy, 1);
        check_val("small_not_valid", s_out_valid, 0);
        @(posedge clk); #1;
        check_val("small_valid", s_out_valid, 1);
        check_val("small_digest", s_out_data, 16'hB4C6);

        // Zero rounds: digest is the seed, busy never rises
        seed = rand_seed();
        accept(seed, 8'd0);
        check_val("r0_busy", busy, 0);
        wait_done(0, seed, "r0");
        drain();

        // Hold under backpressure
        seed = rand_seed();
        accept(seed, 8'd5);
        wait_done(5, model(seed, 5), "hold");
        held = out_data;
        for (int s = 0; s < 10; s++) begin
            check_val("hold_data", out_data, held);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        drain();

        // Randomized seeds, round counts and drain stalls
        for (int k = 0; k < 20; k++) begin
            seed = rand_seed();
            rc = $urandom_range(0, 24);
            accept(seed, RWD'(rc));
            wait_done(rc, model(seed, rc), "rand");
            stall = $urandom_range(0, 3);
            held = out_data;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check_val("rand_hold", out_data, held);
            end
            drain();
        end

        // Asynchronous reset mid-run
        seed = rand_seed();
        accept(seed, 8'd200);
        n = 0;
        while (round_cnt != 8'd50 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("reach_round_50", round_cnt, 50);
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_data", out_data, 0);
        check_val("arst_round_cnt", round_cnt, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_in_ready", in_ready, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        seed = rand_seed();
        accept(seed, 8'd9);
        wait_done(9, model(seed, 9), "post_rst");
        drain();

        // Back-to-back with out_ready tied high
        seed = rand_seed(); seed_b = rand_seed();
        exp_a = model(seed, 3); exp_b = model(seed_b, 7);
        out_ready = 1'b1; in_data = seed; rounds_cfg = 8'd3; in_valid = 1'b1;
        cyc = 0; sent = 0; got = 0; acc2 = 0; oh1 = 0;
        while (got < 2 && cyc < 100) begin
            acc = in_valid && in_ready;
            oh  = out_valid && out_ready;
            cap = out_data;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent == 0) begin
                    in_data = seed_b; rounds_cfg = 8'd7;
                end else begin
                    acc2 = cyc; in_valid = 1'b0;
                end
                sent++;
            end
            if (oh) begin
                if (got == 0) begin
                    check_val("b2b_digest_a", cap, exp_a);
                    oh1 = cyc;
                end else begin
                    check_val("b2b_digest_b", cap, exp_b);
                end
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("b2b_count", got, 2);
        check_val("b2b_gap", acc2 > oh1, 1);

`ifdef MIX_ROUND_ENGINE_ABORT_EN
        seed = rand_seed();
        accept(seed, 8'd10);
        n = 0;
        while (round_cnt != 8'd4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_round_cnt", round_cnt, 0);
        check_val("abort_busy", busy, 0);
        for (int s = 0; s < 3; s++) begin
            check_val("abort_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        seed = rand_seed();
        accept(seed, 8'd2);
        wait_done(2, model(seed, 2), "abort_done");
        abort = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            check_val("done_abort_valid", out_valid, 1);
            check_val("done_abort_data", out_data, model(seed, 2));
        end
        abort = 1'b0;
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
